// File: rtl/lr_shift_pkg.sv
// Shared types and constants for the LRShift bidirectional shift register.
// Used by lr_shift_reg, lr_shift_reg_if and lr_shift_mode_dec.
package lr_shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Encoding matches the {l, r} control pair so the decode is a straight cast.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/lr_shift_reg_if.sv
// Control/data bundle for lr_shift_reg.
// Optional LRSHIFT_ROTATE_EN adds the rot control signal.
interface lr_shift_reg_if
  import lr_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             l;
  logic             r;
  logic             si;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
`ifdef LRSHIFT_ROTATE_EN
  logic             rot;

  modport master (output l, output r, output si, output in, output rot, input out);
  modport slave  (input l, input r, input si, input in, input rot, output out);
`else
  modport master (output l, output r, output si, output in, input out);
  modport slave  (input l, input r, input si, input in, output out);
`endif

endinterface

// File: rtl/lr_shift_mode_dec.sv
// Combinational decode of the {l, r} control pair into the shift mode.
module lr_shift_mode_dec
  import lr_shift_pkg::*;
(
  input  logic  l,
  input  logic  r,
  output mode_e mode
);

  always_comb begin
    mode = mode_e'({l, r});
  end

endmodule

// File: rtl/lr_shift_reg.sv
// Bidirectional shift register with serial input and parallel load (LRShift).
// Define LRSHIFT_ROTATE_EN to add the rot control, which turns shifts into rotates.
module lr_shift_reg
  import lr_shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  lr_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             shl_fill;
  logic             shr_fill;
  mode_e            mode;

  lr_shift_mode_dec u_mode_dec (
    .l    (bus.l),
    .r    (bus.r),
    .mode (mode)
  );

`ifdef LRSHIFT_ROTATE_EN
  // When rotating, the bit shifted out wraps around to the vacated end.
  always_comb begin
    shl_fill = bus.rot ? out_q[WIDTH-1] : bus.si;
    shr_fill = bus.rot ? out_q[0]       : bus.si;
  end
`else
  always_comb begin
    shl_fill = bus.si;
    shr_fill = bus.si;
  end
`endif

  always_comb begin
    out_d = out_q;
    unique case (mode)
      MODE_HOLD: out_d = out_q;
      MODE_SHL:  out_d = {out_q[WIDTH-2:0], shl_fill};
      MODE_SHR:  out_d = {shr_fill, out_q[WIDTH-1:1]};
      MODE_LOAD: out_d = bus.in;
      default:   out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_lr_shift_reg.sv
// Directed bench for lr_shift_reg; rotate vectors run when LRSHIFT_ROTATE_EN is defined.
module tb_lr_shift_reg;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  lr_shift_reg_if #(.WIDTH(W)) bus ();

  lr_shift_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // Apply one set of controls across one rising edge; sample 1 time unit later.
  task automatic step(input logic l, input logic r, input logic si, input logic [W-1:0] d);
    bus.l  = l;
    bus.r  = r;
    bus.si = si;
    bus.in = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_v;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.l    = 1'b0;
    bus.r    = 1'b0;
    bus.si   = 1'b0;
    bus.in   = '0;
`ifdef LRSHIFT_ROTATE_EN
    bus.rot  = 1'b0;
`endif

    // Reset overrides a load request.
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    check_eq("reset", bus.out, 8'h00);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    check_eq("post_reset_hold", bus.out, 8'h00);

    // Load then hold; si and in must be ignored in hold.
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    check_eq("load_a5", bus.out, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h3C);
      check_eq("hold_a5", bus.out, 8'hA5);
    end

    // Shift left.
    step(1'b1, 1'b1, 1'b0, 8'h81);
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    check_eq("shl_si0", bus.out, 8'h02);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check_eq("shl_si1", bus.out, 8'h05);

    // Shift right inserts si, not the old MSB.
    step(1'b1, 1'b1, 1'b0, 8'h81);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check_eq("shr_si1", bus.out, 8'hC0);
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    check_eq("shr_si0", bus.out, 8'h60);

    // Fill with ones from the right, then drain with zeros from the left.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    exp_v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      exp_v = {exp_v[6:0], 1'b1};
      check_eq("fill_shl", bus.out, exp_v);
    end
    check_eq("fill_full", bus.out, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'hFF);
      exp_v = {1'b0, exp_v[7:1]};
      check_eq("drain_shr", bus.out, exp_v);
    end
    check_eq("drain_empty", bus.out, 8'h00);

    // Reset in the middle of a shift sequence.
    step(1'b1, 1'b1, 1'b0, 8'h81);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check_eq("mid_shl", bus.out, 8'h03);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check_eq("mid_reset", bus.out, 8'h00);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 8'h00);
    check_eq("after_mid_reset", bus.out, 8'h01);

`ifdef LRSHIFT_ROTATE_EN
    bus.rot = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'h81);
    check_eq("rot_load", bus.out, 8'h81);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("rol", bus.out, 8'h03);
    step(1'b1, 1'b1, 1'b0, 8'h81);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("ror_si0", bus.out, 8'hC0);
    step(1'b1, 1'b1, 1'b0, 8'h81);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check_eq("ror_si1", bus.out, 8'hC0);
    step(1'b1, 1'b1, 1'b0, 8'h80);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check_eq("ror_lsb0", bus.out, 8'h40);
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    check_eq("rot_hold", bus.out, 8'h40);
    bus.rot = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h81);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("rot_off_shl", bus.out, 8'h02);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
